// File: rtl/op_pkg.sv
// Shared frontend definitions: cacheline geometry used by the L1I arbiter, L0 and BP.
package op_pkg;

    localparam int unsigned LINE_BYTES = 64;
    localparam int unsigned LINE_BITS  = LINE_BYTES * 8;

    typedef logic [LINE_BITS-1:0] cacheline_t;

endpackage

// File: rtl/l1i_fetch_arbiter.sv
// Owner of the single L1I read port: arbitrates BP demand vs. execute redirects, drains squashed responses.
// Optional next-line prefetch after each delivered demand: define L1I_NEXT_LINE_PREFETCH_EN.
module l1i_fetch_arbiter
    import op_pkg::*;
#(
    parameter int unsigned PC_WIDTH  = 64,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                   clk_in,
    input  logic                   rst_in,

    input  logic                   bp_req_valid,
    input  logic [PC_WIDTH-1:0]    bp_req_addr,
    output logic                   bp_req_ready,

    input  logic                   redirect_valid,
    input  logic [PC_WIDTH-1:0]    redirect_addr,

    output logic                   l1i_req_valid,
    output logic [PC_WIDTH-1:0]    l1i_req_addr,
    input  logic                   l1i_req_ready,
    input  logic                   l1i_resp_valid,
    input  logic [LINE_BITS-1:0]   l1i_resp_data,

    output logic                   bp_resp_valid,
    output logic [PC_WIDTH-1:0]    bp_resp_pc,
    output logic [LINE_BITS-1:0]   bp_resp_data,

    output logic                   l0_fill_valid,
    output logic [PC_WIDTH-1:0]    l0_fill_addr,
    output logic [LINE_BITS-1:0]   l0_fill_data,

    output logic [CNT_WIDTH-1:0]   squash_count,
    output logic                   busy
);

    localparam logic [PC_WIDTH-1:0]  LINE_MASK = ~PC_WIDTH'(LINE_BYTES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DRAIN
    } state_e;

    // Request that owns (or will own) the L1I port next.
    typedef struct packed {
        logic [PC_WIDTH-1:0] pc;
`ifdef L1I_NEXT_LINE_PREFETCH_EN
        logic                pf;
`endif
    } pend_t;

    function automatic logic [PC_WIDTH-1:0] line_of(input logic [PC_WIDTH-1:0] addr);
        return addr & LINE_MASK;
    endfunction

    state_e                 state_q;
    pend_t                  pend_q;
    logic                   bp_resp_valid_q;
    logic [PC_WIDTH-1:0]    bp_resp_pc_q;
    logic                   l0_fill_valid_q;
    logic [PC_WIDTH-1:0]    l0_fill_addr_q;
    cacheline_t             line_q;
    logic [CNT_WIDTH-1:0]   squash_q;

`ifdef L1I_NEXT_LINE_PREFETCH_EN
    logic                   pf_arm_q;
    logic [PC_WIDTH-1:0]    pf_addr_q;
`endif

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q         <= ST_IDLE;
            pend_q          <= '0;
            bp_resp_valid_q <= 1'b0;
            bp_resp_pc_q    <= '0;
            l0_fill_valid_q <= 1'b0;
            l0_fill_addr_q  <= '0;
            line_q          <= '0;
            squash_q        <= '0;
`ifdef L1I_NEXT_LINE_PREFETCH_EN
            pf_arm_q        <= 1'b0;
            pf_addr_q       <= '0;
`endif
        end else begin
            bp_resp_valid_q <= 1'b0;
            l0_fill_valid_q <= 1'b0;
`ifdef L1I_NEXT_LINE_PREFETCH_EN
            pf_arm_q        <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (redirect_valid) begin
                        pend_q.pc <= redirect_addr;
`ifdef L1I_NEXT_LINE_PREFETCH_EN
                        pend_q.pf <= 1'b0;
`endif
                        state_q   <= ST_REQ;
                    end else if (bp_req_valid) begin
                        pend_q.pc <= bp_req_addr;
`ifdef L1I_NEXT_LINE_PREFETCH_EN
                        pend_q.pf <= 1'b0;
`endif
                        state_q   <= ST_REQ;
`ifdef L1I_NEXT_LINE_PREFETCH_EN
                    end else if (pf_arm_q) begin
                        pend_q.pc <= pf_addr_q;
                        pend_q.pf <= 1'b1;
                        state_q   <= ST_REQ;
`endif
                    end
                end

                // Address may still change until L1I accepts; after acceptance the old request is live.
                ST_REQ: begin
                    if (redirect_valid) begin
                        pend_q.pc <= redirect_addr;
`ifdef L1I_NEXT_LINE_PREFETCH_EN
                        pend_q.pf <= 1'b0;
`endif
                        state_q   <= l1i_req_ready ? ST_DRAIN : ST_REQ;
                    end else if (l1i_req_ready) begin
                        state_q   <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    if (l1i_resp_valid && redirect_valid) begin
                        if (squash_q != CNT_MAX) squash_q <= squash_q + CNT_WIDTH'(1);
                        pend_q.pc <= redirect_addr;
`ifdef L1I_NEXT_LINE_PREFETCH_EN
                        pend_q.pf <= 1'b0;
`endif
                        state_q   <= ST_REQ;
                    end else if (l1i_resp_valid) begin
                        line_q          <= l1i_resp_data;
                        l0_fill_valid_q <= 1'b1;
                        l0_fill_addr_q  <= line_of(pend_q.pc);
`ifdef L1I_NEXT_LINE_PREFETCH_EN
                        if (!pend_q.pf) begin
                            bp_resp_valid_q <= 1'b1;
                            bp_resp_pc_q    <= pend_q.pc;
                            pf_arm_q        <= 1'b1;
                            pf_addr_q       <= line_of(pend_q.pc) + PC_WIDTH'(LINE_BYTES);
                        end
`else
                        bp_resp_valid_q <= 1'b1;
                        bp_resp_pc_q    <= pend_q.pc;
`endif
                        state_q         <= ST_IDLE;
                    end else if (redirect_valid) begin
                        pend_q.pc <= redirect_addr;
`ifdef L1I_NEXT_LINE_PREFETCH_EN
                        pend_q.pf <= 1'b0;
`endif
                        state_q   <= ST_DRAIN;
                    end
                end

                // Latest redirect wins, including one arriving with the squashed response.
                ST_DRAIN: begin
                    if (redirect_valid) begin
                        pend_q.pc <= redirect_addr;
`ifdef L1I_NEXT_LINE_PREFETCH_EN
                        pend_q.pf <= 1'b0;
`endif
                    end
                    if (l1i_resp_valid) begin
                        if (squash_q != CNT_MAX) squash_q <= squash_q + CNT_WIDTH'(1);
                        state_q <= ST_REQ;
                    end
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bp_req_ready  = !rst_in && (state_q == ST_IDLE) && !redirect_valid;
    assign l1i_req_valid = (state_q == ST_REQ);
    assign l1i_req_addr  = line_of(pend_q.pc);
    assign busy          = (state_q != ST_IDLE);

    assign bp_resp_valid = bp_resp_valid_q;
    assign bp_resp_pc    = bp_resp_pc_q;
    assign bp_resp_data  = line_q;
    assign l0_fill_valid = l0_fill_valid_q;
    assign l0_fill_addr  = l0_fill_addr_q;
    assign l0_fill_data  = line_q;
    assign squash_count  = squash_q;

endmodule

// File: tb/tb_l1i_fetch_arbiter.sv
// Directed bench for l1i_fetch_arbiter with a transaction-level reference model checked every cycle.
module tb_l1i_fetch_arbiter;

    logic           clk_in = 1'b0;
    logic           rst_in;
    logic           bp_req_valid;
    logic [63:0]    bp_req_addr;
    logic           bp_req_ready;
    logic           redirect_valid;
    logic [63:0]    redirect_addr;
    logic           l1i_req_valid;
    logic [63:0]    l1i_req_addr;
    logic           l1i_req_ready;
    logic           l1i_resp_valid;
    logic [511:0]   l1i_resp_data;
    logic           bp_resp_valid;
    logic [63:0]    bp_resp_pc;
    logic [511:0]   bp_resp_data;
    logic           l0_fill_valid;
    logic [63:0]    l0_fill_addr;
    logic [511:0]   l0_fill_data;
    logic [15:0]    squash_count;
    logic           busy;

    l1i_fetch_arbiter dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .bp_req_valid   (bp_req_valid),
        .bp_req_addr    (bp_req_addr),
        .bp_req_ready   (bp_req_ready),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .l1i_req_valid  (l1i_req_valid),
        .l1i_req_addr   (l1i_req_addr),
        .l1i_req_ready  (l1i_req_ready),
        .l1i_resp_valid (l1i_resp_valid),
        .l1i_resp_data  (l1i_resp_data),
        .bp_resp_valid  (bp_resp_valid),
        .bp_resp_pc     (bp_resp_pc),
        .bp_resp_data   (bp_resp_data),
        .l0_fill_valid  (l0_fill_valid),
        .l0_fill_addr   (l0_fill_addr),
        .l0_fill_data   (l0_fill_data),
        .squash_count   (squash_count),
        .busy           (busy)
    );

    always #5 clk_in = ~clk_in;

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic logic [511:0] mk_line(input int unsigned seed);
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = seed * 32'h9E37_79B9 + 32'(i);
        return r;
    endfunction

    function automatic logic [63:0] align64(input logic [63:0] a);
        return a - (a % 64);
    endfunction

    // Reference model: tracks "a request wants the port", "a request is outstanding", "outstanding is dead".
    bit           m_want, m_live, m_dead;
    logic [63:0]  m_pc;
    logic [15:0]  m_sq;
    bit           e_bpv, e_fv;
    logic [63:0]  e_pc, e_faddr;
    logic [511:0] e_data;

    always @(posedge clk_in or posedge rst_in) begin
        bit was_idle, can_issue;
        if (rst_in) begin
            m_want = 0; m_live = 0; m_dead = 0; m_pc = '0; m_sq = '0;
            e_bpv = 0; e_fv = 0; e_pc = '0; e_faddr = '0; e_data = '0;
        end else begin
            was_idle  = !m_want && !m_live;
            can_issue = m_want && !m_live;
            e_bpv = 0;
            e_fv  = 0;
            if (m_live && l1i_resp_valid) begin
                if (m_dead || redirect_valid) begin
                    if (m_sq != 16'hFFFF) m_sq = m_sq + 16'd1;
                end else begin
                    e_bpv = 1; e_fv = 1;
                    e_pc = m_pc; e_faddr = align64(m_pc); e_data = l1i_resp_data;
                end
                m_live = 0;
                m_dead = 0;
            end else if (can_issue && l1i_req_ready) begin
                m_live = 1; m_dead = 0; m_want = 0;
            end
            if (redirect_valid) begin
                if (m_live) m_dead = 1;
                m_want = 1;
                m_pc   = redirect_addr;
            end else if (was_idle && bp_req_valid) begin
                m_want = 1;
                m_pc   = bp_req_addr;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk_in) begin
        bit exp_reqv;
        exp_reqv = !rst_in && m_want && !m_live;
        chk("cyc_bp_req_ready", 512'(bp_req_ready),
            512'(!rst_in && !m_want && !m_live && !redirect_valid));
        chk("cyc_l1i_req_valid", 512'(l1i_req_valid), 512'(exp_reqv));
        if (exp_reqv) chk("cyc_l1i_req_addr", 512'(l1i_req_addr), 512'(align64(m_pc)));
        chk("cyc_busy", 512'(busy), 512'(!rst_in && (m_want || m_live)));
        chk("cyc_bp_resp_valid", 512'(bp_resp_valid), 512'(e_bpv));
        chk("cyc_l0_fill_valid", 512'(l0_fill_valid), 512'(e_fv));
        if (e_bpv) begin
            chk("cyc_bp_resp_pc", 512'(bp_resp_pc), 512'(e_pc));
            chk("cyc_bp_resp_data", bp_resp_data, e_data);
        end
        if (e_fv) begin
            chk("cyc_l0_fill_addr", 512'(l0_fill_addr), 512'(e_faddr));
            chk("cyc_l0_fill_data", l0_fill_data, e_data);
        end
        chk("cyc_squash_count", 512'(squash_count), 512'(m_sq));
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic req_bp(input logic [63:0] a);
        bp_req_valid = 1'b1; bp_req_addr = a;
        step();
        bp_req_valid = 1'b0;
    endtask

    task automatic accept();
        l1i_req_ready = 1'b1;
        step();
        l1i_req_ready = 1'b0;
    endtask

    task automatic resp(input logic [511:0] d);
        l1i_resp_valid = 1'b1; l1i_resp_data = d;
        step();
        l1i_resp_valid = 1'b0;
    endtask

    task automatic redir(input logic [63:0] a);
        redirect_valid = 1'b1; redirect_addr = a;
        step();
        redirect_valid = 1'b0;
    endtask

    logic [511:0] d;

    initial begin
        rst_in = 1'b1;
        bp_req_valid = 0; bp_req_addr = '0;
        redirect_valid = 0; redirect_addr = '0;
        l1i_req_ready = 0; l1i_resp_valid = 0; l1i_resp_data = '0;
        step(); step();
        chk("rst_busy", 512'(busy), 512'(0));
        chk("rst_ready", 512'(bp_req_ready), 512'(0));
        rst_in = 1'b0;
        step();

        // 1: basic demand, response 3 cycles after acceptance
        bp_req_valid = 1'b1; bp_req_addr = 64'h1008;
        #1 chk("t1_ready", 512'(bp_req_ready), 512'(1));
        step();
        bp_req_valid = 1'b0;
        chk("t1_req_valid", 512'(l1i_req_valid), 512'(1));
        chk("t1_req_addr", 512'(l1i_req_addr), 512'(64'h1000));
        accept();
        step(); step();
        d = mk_line(1);
        resp(d);
        chk("t1_bp_resp_valid", 512'(bp_resp_valid), 512'(1));
        chk("t1_bp_resp_pc", 512'(bp_resp_pc), 512'(64'h1008));
        chk("t1_fill_addr", 512'(l0_fill_addr), 512'(64'h1000));
        chk("t1_data", bp_resp_data, d);
        step();

        // 2: redirect while waiting -> drain, then redirected fetch
        req_bp(64'h1000); accept(); step();
        redir(64'h4000);
        step();
        resp(mk_line(2));
        chk("t2_squash", 512'(squash_count), 512'(1));
        chk("t2_no_resp", 512'(bp_resp_valid), 512'(0));
        chk("t2_req_addr", 512'(l1i_req_addr), 512'(64'h4000));
        accept();
        resp(mk_line(3));
        chk("t2_bp_resp_pc", 512'(bp_resp_pc), 512'(64'h4000));
        step();

        // 3: redirect and response in the same WAIT cycle
        req_bp(64'h1040); accept(); step();
        redirect_valid = 1; redirect_addr = 64'h2000;
        l1i_resp_valid = 1; l1i_resp_data = mk_line(4);
        step();
        redirect_valid = 0; l1i_resp_valid = 0;
        chk("t3_no_bp_resp", 512'(bp_resp_valid), 512'(0));
        chk("t3_no_fill", 512'(l0_fill_valid), 512'(0));
        chk("t3_squash", 512'(squash_count), 512'(2));
        chk("t3_req_addr", 512'(l1i_req_addr), 512'(64'h2000));
        accept();
        resp(mk_line(5));
        chk("t3_bp_resp_pc", 512'(bp_resp_pc), 512'(64'h2000));
        step();

        // 4: two redirects while draining, one dropped response
        req_bp(64'h6000); accept();
        redir(64'h3000);
        redir(64'h5000);
        step();
        resp(mk_line(6));
        chk("t4_squash", 512'(squash_count), 512'(3));
        chk("t4_req_addr", 512'(l1i_req_addr), 512'(64'h5000));
        step();
        accept();
        resp(mk_line(7));
        chk("t4_bp_resp_pc", 512'(bp_resp_pc), 512'(64'h5000));
        chk("t4_squash_hold", 512'(squash_count), 512'(3));
        step();

        // 5: retarget before acceptance, no squash
        req_bp(64'h7000);
        step();
        redir(64'h7040);
        chk("t5_req_addr", 512'(l1i_req_addr), 512'(64'h7040));
        chk("t5_req_valid", 512'(l1i_req_valid), 512'(1));
        step();
        accept();
        resp(mk_line(8));
        chk("t5_bp_resp_pc", 512'(bp_resp_pc), 512'(64'h7040));
        chk("t5_squash", 512'(squash_count), 512'(3));
        step();

        // 7: redirect coinciding with acceptance -> old request squashed
        bp_req_valid = 1; bp_req_addr = 64'h8000;
        step();
        bp_req_valid = 0;
        l1i_req_ready = 1; redirect_valid = 1; redirect_addr = 64'h9000;
        step();
        l1i_req_ready = 0; redirect_valid = 0;
        chk("t7_drain_no_req", 512'(l1i_req_valid), 512'(0));
        chk("t7_busy", 512'(busy), 512'(1));
        resp(mk_line(9));
        chk("t7_squash", 512'(squash_count), 512'(4));
        chk("t7_req_addr", 512'(l1i_req_addr), 512'(64'h9000));
        accept();
        resp(mk_line(10));
        chk("t7_bp_resp_pc", 512'(bp_resp_pc), 512'(64'h9000));
        step();

        // 8: redirect beats a concurrent BP request in IDLE
        bp_req_valid = 1; bp_req_addr = 64'hA000;
        redirect_valid = 1; redirect_addr = 64'hB010;
        #1 chk("t8_ready_low", 512'(bp_req_ready), 512'(0));
        step();
        bp_req_valid = 0; redirect_valid = 0;
        chk("t8_req_addr", 512'(l1i_req_addr), 512'(64'hB000));
        accept();
        resp(mk_line(11));
        chk("t8_bp_resp_pc", 512'(bp_resp_pc), 512'(64'hB010));
        step();

        // 9: top-of-address-space line alignment
        req_bp(64'hFFFF_FFFF_FFFF_FFF8);
        chk("t9_req_addr", 512'(l1i_req_addr), 512'(64'hFFFF_FFFF_FFFF_FFC0));
        accept();
        resp(mk_line(12));
        chk("t9_fill_addr", 512'(l0_fill_addr), 512'(64'hFFFF_FFFF_FFFF_FFC0));
        step();

        // 6: asynchronous reset mid-WAIT
        req_bp(64'hC000); accept(); step();
        rst_in = 1'b1;
        #1;
        chk("t6_busy", 512'(busy), 512'(0));
        chk("t6_req_valid", 512'(l1i_req_valid), 512'(0));
        chk("t6_squash", 512'(squash_count), 512'(0));
        chk("t6_ready_in_reset", 512'(bp_req_ready), 512'(0));
        step();
        rst_in = 1'b0;
        #1 chk("t6_ready_after", 512'(bp_req_ready), 512'(1));
        step(); step();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
